// File: rtl/shape_row_scanner_pkg.sv
// Shared constants, types and state encoding for the sprite-ROM row scanner.
package shape_pkg;

  localparam int ROW_W    = 51;
  localparam int NUM_ROWS = 60;
  localparam int ADDR_W   = 6;
  localparam int COORD_W  = 10;
  localparam int COL_W    = $clog2(ROW_W);

  typedef logic [3:0]         orient_t;
  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } scan_state_t;

  // Screen coordinates wrap modulo 2**COORD_W; no saturation.
  function automatic coord_t coord_add(coord_t base, int unsigned off);
    return base + coord_t'(off);
  endfunction

endpackage

// File: rtl/shape_row_scanner_if.sv
// Scanner bus: ROM read port (address out, registered row back) plus the
// valid/ready pixel-coordinate stream to the compositor.
interface shape_row_scanner_if;
  import shape_pkg::*;

  orient_t rom_orientation;
  addr_t   rom_address;
  row_t    rom_data;

  logic    pix_valid;
  logic    pix_ready;
  coord_t  pix_x;
  coord_t  pix_y;

  modport master (
    output rom_orientation, rom_address, pix_valid, pix_x, pix_y,
    input  rom_data, pix_ready
  );

  modport slave (
    input  rom_orientation, rom_address, pix_valid, pix_x, pix_y,
    output rom_data, pix_ready
  );

endinterface

// File: rtl/shape_row_scanner.sv
// Walks all rows of a sprite ROM for a latched orientation and serialises set
// bits into absolute pixel coordinates; all-zero rows are skipped whole.
module shape_row_scanner
  import shape_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  orient_t                    orientation,
  input  coord_t                     origin_x,
  input  coord_t                     origin_y,
  output logic                       busy,
  output logic                       done,
  shape_row_scanner_if.master        bus
);

  scan_state_t r_state;
  addr_t       r_row;
  col_t        r_col;
  row_t        r_sr;
  orient_t     r_orient;
  coord_t      r_ox;
  coord_t      r_oy;
  addr_t       r_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_pix_valid;
  coord_t      r_pix_x;
  coord_t      r_pix_y;

  logic        w_adv;
  logic        w_last_row;
  logic        w_last_col;
  logic        w_row_zero;
  addr_t       w_row_nxt;

  // The output slot is free when empty or being drained this cycle.
  assign w_adv      = !r_pix_valid || bus.pix_ready;
  assign w_last_row = (r_row == addr_t'(NUM_ROWS - 1));
  assign w_last_col = (r_col == col_t'(ROW_W - 1));
  assign w_row_zero = (bus.rom_data == '0);
  assign w_row_nxt  = r_row + addr_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_sr        <= '0;
      r_orient    <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_pix_valid && bus.pix_ready)
        r_pix_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_orient <= orientation;
            r_ox     <= origin_x;
            r_oy     <= origin_y;
            r_row    <= '0;
            r_addr   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end

        // Address is already registered; this cycle covers the ROM latency.
        S_FETCH: r_state <= S_LOAD;

        S_LOAD: begin
          r_sr  <= bus.rom_data;
          r_col <= '0;
          if (!w_row_zero) begin
            r_state <= S_SCAN;
          end else if (w_last_row) begin
            r_state <= S_DRAIN;
          end else begin
            r_row   <= w_row_nxt;
            r_addr  <= w_row_nxt;
            r_state <= S_FETCH;
          end
        end

        S_SCAN: begin
          if (w_adv) begin
            // Overrides the acceptance clear above, giving 1 pixel/clk.
            r_pix_valid <= r_sr[ROW_W-1];
            if (r_sr[ROW_W-1]) begin
              r_pix_x <= coord_add(r_ox, 32'(r_col));
              r_pix_y <= coord_add(r_oy, 32'(r_row));
            end
            r_sr  <= r_sr << 1;
            r_col <= r_col + col_t'(1);
            if (w_last_col) begin
              if (w_last_row) begin
                r_state <= S_DRAIN;
              end else begin
                r_row   <= w_row_nxt;
                r_addr  <= w_row_nxt;
                r_state <= S_FETCH;
              end
            end
          end
        end

        S_DRAIN: begin
          if (w_adv) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        // Start is not sampled here, so a start coinciding with done is dropped.
        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign bus.rom_orientation = r_orient;
  assign bus.rom_address     = r_addr;
  assign bus.pix_valid       = r_pix_valid;
  assign bus.pix_x           = r_pix_x;
  assign bus.pix_y           = r_pix_y;

endmodule

// File: tb/tb_shape_row_scanner.sv
// Bench for shape_row_scanner: behavioural ROM + pixel-list model, random images/backpressure.
module tb_shape_row_scanner;
  import shape_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b1;
  logic    start = 1'b0;
  orient_t orientation = '0;
  coord_t  origin_x = '0;
  coord_t  origin_y = '0;
  logic    busy;
  logic    done;

  shape_row_scanner_if bus();

  shape_row_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .orientation (orientation),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  row_t img [16][NUM_ROWS];
  logic [2*COORD_W-1:0] exp_q [$];
  logic [2*COORD_W-1:0] got_q [$];

  bit rnd_ready = 1'b0;
  bit hold_low  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered-latency ROM model.
  always @(posedge clk) begin
    if (int'(bus.rom_address) < NUM_ROWS)
      bus.rom_data <= img[int'(bus.rom_orientation)][int'(bus.rom_address)];
    else
      bus.rom_data <= '0;
  end

  // Downstream backpressure driver.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low)       bus.pix_ready = 1'b0;
      else if (rnd_ready) bus.pix_ready = ($urandom_range(0, 9) < 7);
      else                bus.pix_ready = 1'b1;
    end
  end

  function automatic row_t rand_row();
    row_t a, b;
    a = row_t'({$urandom, $urandom});
    b = row_t'({$urandom, $urandom});
    if ($urandom_range(0, 9) < 4) return '0;
    return a & b;
  endfunction

  task automatic build_images();
    for (int o = 0; o < 16; o++)
      for (int r = 0; r < NUM_ROWS; r++)
        img[o][r] = (o >= 2) ? rand_row() : '0;
    for (int r = 2; r < NUM_ROWS; r++)
      if (r != 15 && (r < 23 || r > 36)) img[0][r] = rand_row();
    img[0][0][ROW_W-1-25] = 1'b1;
    for (int c = 23; c <= 27; c++) img[0][1][ROW_W-1-c] = 1'b1;
    img[0][15][ROW_W-1-0]  = 1'b1;
    img[0][15][ROW_W-1-10] = 1'b1;
    img[2][0]  = '1;
    img[2][NUM_ROWS-1] = '1;
  endtask

  // Expected pixel list: raster order over set bits, coordinates mod 2**COORD_W.
  task automatic model_scan(input orient_t o, input coord_t ox, input coord_t oy);
    coord_t x, y;
    exp_q.delete();
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < ROW_W; c++)
        if (img[int'(o)][r][ROW_W-1-c]) begin
          x = coord_t'(int'(ox) + c);
          y = coord_t'(int'(oy) + r);
          exp_q.push_back({x, y});
        end
  endtask

  function automatic int exp_cycles(input orient_t o);
    int n = 2 * NUM_ROWS + 1;
    for (int r = 0; r < NUM_ROWS; r++)
      if (img[int'(o)][r] != '0) n += ROW_W;
    return n;
  endfunction

  // Compare process: every accepted pixel against the model, hold while stalled.
  initial begin
    logic   stall_prev = 1'b0;
    logic   done_prev = 1'b0;
    coord_t px = '0, py = '0;
    logic [2*COORD_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev) begin
          chk("hold_valid", 32'(bus.pix_valid), 32'd1);
          chk("hold_x", 32'(bus.pix_x), 32'(px));
          chk("hold_y", 32'(bus.pix_y), 32'(py));
        end
        if (bus.pix_valid && bus.pix_ready) begin
          chk("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pixel_xy", 32'({bus.pix_x, bus.pix_y}), 32'(e));
          end
          got_q.push_back({bus.pix_x, bus.pix_y});
        end
        if (done) begin
          chk("done_all_pixels", 32'(exp_q.size()), 32'd0);
          chk("done_single_cycle", 32'(done_prev), 32'd0);
        end
        stall_prev = bus.pix_valid && !bus.pix_ready;
        px = bus.pix_x;
        py = bus.pix_y;
        done_prev = done;
      end else begin
        stall_prev = 1'b0;
        done_prev  = 1'b0;
      end
    end
  end

  task automatic run_scan(input orient_t o, input coord_t ox, input coord_t oy,
                          input bit mid_start, input bit stall, input bit chk_cyc);
    int     cyc;
    bit     stalled;
    coord_t sx, sy;
    got_q.delete();
    model_scan(o, ox, oy);
    @(posedge clk); #1;
    start = 1'b1; orientation = o; origin_x = ox; origin_y = oy;
    @(posedge clk); #1;
    start = 1'b0;
    orientation = orient_t'($urandom);
    origin_x = coord_t'($urandom);
    origin_y = coord_t'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("rom_orientation", 32'(bus.rom_orientation), 32'(o));
    chk("rom_address_row0", 32'(bus.rom_address), 32'd0);
    cyc = 0;
    stalled = 1'b0;
    while (!done && cyc < 20000) begin
      if (mid_start && cyc == 200) begin
        start = 1'b1; orientation = 4'd1; origin_x = '0; origin_y = '0;
      end
      if (mid_start && cyc == 201) begin
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_orientation", 32'(bus.rom_orientation), 32'(o));
      end
      if (mid_start && cyc == 203) start = 1'b0;
      if (stall && !stalled && bus.pix_valid && bus.pix_y == coord_t'(int'(oy) + 1)) begin
        stalled  = 1'b1;
        hold_low = 1'b1;
        @(posedge clk); #2;
        cyc++;
        sx = bus.pix_x;
        sy = bus.pix_y;
        chk("stall_pending", 32'(bus.pix_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #2;
          cyc++;
          chk("stall_valid", 32'(bus.pix_valid), 32'd1);
          chk("stall_xy", 32'({bus.pix_x, bus.pix_y}), 32'({sx, sy}));
        end
        hold_low = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("scan_finished", 32'(done), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    if (chk_cyc) chk("scan_cycles", 32'(cyc), 32'(exp_cycles(o)));
    @(posedge clk); #1;
    chk("done_cleared", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_mid;
    build_images();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_pix_xy", 32'({bus.pix_x, bus.pix_y}), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_address), 32'd0);
    chk("rst_rom_orient", 32'(bus.rom_orientation), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 1: basic scan of the orientation-0 image.
    run_scan(4'd0, 10'd100, 10'd40, 1'b0, 1'b0, 1'b1);
    chk("t1_count", 32'(got_q.size() >= 6), 32'd1);
    if (got_q.size() >= 6) begin
      chk("t1_px0", 32'(got_q[0]), 32'({10'd125, 10'd40}));
      chk("t1_px1", 32'(got_q[1]), 32'({10'd123, 10'd41}));
      chk("t1_px2", 32'(got_q[2]), 32'({10'd124, 10'd41}));
      chk("t1_px3", 32'(got_q[3]), 32'({10'd125, 10'd41}));
      chk("t1_px4", 32'(got_q[4]), 32'({10'd126, 10'd41}));
      chk("t1_px5", 32'(got_q[5]), 32'({10'd127, 10'd41}));
    end
    cnt_mid = 0;
    foreach (got_q[i])
      if (got_q[i][COORD_W-1:0] >= 10'd63 && got_q[i][COORD_W-1:0] <= 10'd76) cnt_mid++;
    chk("t1_rows23_36_empty", 32'(cnt_mid), 32'd0);

    // 2: five-cycle stall with a pixel pending.
    run_scan(4'd0, 10'd100, 10'd40, 1'b0, 1'b1, 1'b0);

    // 3: empty image -> no pixels, minimum scan length.
    run_scan(4'd1, 10'd300, 10'd500, 1'b0, 1'b0, 1'b1);
    chk("t3_no_pixels", 32'(got_q.size()), 32'd0);

    // 4: x wrap on row 15.
    run_scan(4'd0, 10'd1020, 10'd40, 1'b0, 1'b0, 1'b1);
    n = 0;
    foreach (got_q[i])
      if (got_q[i][COORD_W-1:0] == 10'd55) begin
        if (n == 0) chk("t4_col0", 32'(got_q[i][2*COORD_W-1:COORD_W]), 32'd1020);
        if (n == 1) chk("t4_col10_wrap", 32'(got_q[i][2*COORD_W-1:COORD_W]), 32'd6);
        n++;
      end
    chk("t4_row15_count", 32'(n), 32'd2);

    // 5: start during a scan is ignored.
    run_scan(4'd0, 10'd100, 10'd40, 1'b1, 1'b0, 1'b1);

    // 6: reset in the middle of row 15.
    model_scan(4'd0, 10'd100, 10'd40);
    got_q.delete();
    @(posedge clk); #1;
    start = 1'b1; orientation = 4'd0; origin_x = 10'd100; origin_y = 10'd40;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(bus.pix_valid && bus.pix_y == 10'd55) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reached_row15", 32'(bus.pix_y), 32'd55);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.pix_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 chk("t6_no_done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_scan(4'd0, 10'd100, 10'd40, 1'b0, 1'b0, 1'b1);
    chk("t6_restart_count", 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0)
      chk("t6_restart_px0", 32'(got_q[0]), 32'({10'd125, 10'd40}));

    // Random orientations, origins and backpressure.
    for (int k = 0; k < 6; k++) begin
      rnd_ready = k[0];
      run_scan(orient_t'($urandom_range(2, 15)), coord_t'($urandom), coord_t'($urandom),
               1'b0, 1'b0, !k[0]);
    end
    rnd_ready = 1'b0;
    run_scan(4'd2, 10'd1000, 10'd1000, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
